// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types for the MEM stage
package cpu_pkg;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  localparam int DWORD_BYTES = 8;

  typedef logic [DWORD_BYTES-1:0] be_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/acknowledge bus
interface mem_access_stage_if;
  import cpu_pkg::*;

  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  be_t         dmem_be;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_access_stage_byte_lane_align.sv
// rtl/mem_access_stage_byte_lane_align.sv - little-endian byte lane steering
module byte_lane_align
  import cpu_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic        byte_en,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output be_t         be,
  output logic [63:0] wdata,
  output logic [63:0] load_byte
);

  always_comb begin
    be        = byte_en ? (be_t'(1) << offset) : '1;
    wdata     = byte_en ? {DWORD_BYTES{store_data[7:0]}} : store_data;
    load_byte = {56'b0, rdata[8*offset +: 8]};
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - LEGv8 MEM stage with variable-latency memory and timeout
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [63:0]        ex_alu_result,
  input  logic [63:0]        ex_db,
  input  logic [4:0]         ex_rd,
  input  logic               ex_mem_wr,
  input  logic               ex_mem_to_reg,
  input  logic               ex_reg_wr,
  input  logic               ex_byte,
  mem_access_stage_if.master dmem,
  output logic               stall,
  output logic               fault,
  output logic               wb_valid,
  output logic [63:0]        wb_result,
  output logic [4:0]         wb_rd,
  output logic               wb_reg_wr
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  mem_state_t       state;
  logic [CNT_W-1:0] counter;

  logic        memop, misaligned, req, ack, abort, complete;
  be_t         lane_be;
  logic [63:0] lane_wdata, load_byte;

  assign memop      = ex_valid & (ex_mem_wr | ex_mem_to_reg);
  assign misaligned = memop & ~ex_byte & (ex_alu_result[2:0] != 3'b0);
  assign ack        = dmem.dmem_ack;
  assign req        = (state == WAIT) | (memop & ~misaligned);
  assign abort      = (state == WAIT) & ~ack & (counter == MAX_CNT);
  assign complete   = req & ack;
  assign stall      = req & ~ack & ~abort;

  byte_lane_align u_align (
    .offset     (ex_alu_result[2:0]),
    .byte_en    (ex_byte),
    .store_data (ex_db),
    .rdata      (dmem.dmem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_byte  (load_byte)
  );

  // Bus fields are forced to zero whenever no request is outstanding.
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & ex_mem_wr;
  assign dmem.dmem_addr  = req ? {ex_alu_result[63:3], 3'b0} : 64'b0;
  assign dmem.dmem_wdata = req ? lane_wdata : 64'b0;
  assign dmem.dmem_be    = req ? lane_be : be_t'(0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      fault     <= 1'b0;
      wb_valid  <= 1'b0;
      wb_result <= 64'b0;
      wb_rd     <= 5'b0;
      wb_reg_wr <= 1'b0;
    end else begin
      fault <= 1'b0;

      case (state)
        IDLE: if (req && !ack) begin
          state   <= WAIT;
          counter <= CNT_W'(1);
        end
        WAIT: if (ack || abort) begin
          state   <= IDLE;
          counter <= '0;
        end else begin
          counter <= counter + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (stall) begin
        wb_valid  <= 1'b0;
        wb_reg_wr <= 1'b0;
      end else if (abort || misaligned) begin
        fault     <= 1'b1;
        wb_valid  <= 1'b1;
        wb_rd     <= ex_rd;
        wb_reg_wr <= 1'b0;
      end else if (complete) begin
        // A store wins over a simultaneous load flag and never writes back.
        wb_valid  <= 1'b1;
        wb_rd     <= ex_rd;
        wb_reg_wr <= ex_reg_wr & ~ex_mem_wr;
        if (ex_mem_wr)    wb_result <= ex_alu_result;
        else if (ex_byte) wb_result <= load_byte;
        else              wb_result <= dmem.dmem_rdata;
      end else if (ex_valid) begin
        wb_valid  <= 1'b1;
        wb_rd     <= ex_rd;
        wb_reg_wr <= ex_reg_wr;
        wb_result <= ex_alu_result;
      end else begin
        wb_valid  <= 1'b0;
        wb_reg_wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_wr, ex_mem_to_reg, ex_reg_wr, ex_byte;
  logic [63:0] ex_alu_result, ex_db;
  logic [4:0]  ex_rd;
  logic        stall, fault, wb_valid, wb_reg_wr;
  logic [63:0] wb_result;
  logic [4:0]  wb_rd;

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage_if dmem ();

  mem_access_stage #(.MAX_WAIT(15), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_db         (ex_db),
    .ex_rd         (ex_rd),
    .ex_mem_wr     (ex_mem_wr),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_wr     (ex_reg_wr),
    .ex_byte       (ex_byte),
    .dmem          (dmem.master),
    .stall         (stall),
    .fault         (fault),
    .wb_valid      (wb_valid),
    .wb_result     (wb_result),
    .wb_rd         (wb_rd),
    .wb_reg_wr     (wb_reg_wr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_mem_wr = 0; ex_mem_to_reg = 0; ex_reg_wr = 0; ex_byte = 0;
    ex_alu_result = 0; ex_db = 0; ex_rd = 0;
    dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    vectors++; if (wb_result !== 64'h0) begin miscompares++; $display("FAIL reset_wb_result got %h exp 0", wb_result); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b exp 0", fault); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", dmem.dmem_req); end
    vectors++; if (dmem.dmem_be !== 8'h00) begin miscompares++; $display("FAIL reset_idle_be got %h exp 00", dmem.dmem_be); end
    rst = 0;
    step();
  endtask

  task automatic test_alu();
    ex_valid = 1; ex_alu_result = 64'h1234; ex_rd = 5; ex_reg_wr = 1;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu_stall got %b exp 0", stall); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL alu_req got %b exp 0", dmem.dmem_req); end
    step();
    idle_inputs();
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL alu_wb_valid got %b exp 1", wb_valid); end
    vectors++; if (wb_result !== 64'h1234) begin miscompares++; $display("FAIL alu_wb_result got %h exp 1234", wb_result); end
    vectors++; if (wb_rd !== 5'd5) begin miscompares++; $display("FAIL alu_wb_rd got %0d exp 5", wb_rd); end
    vectors++; if (wb_reg_wr !== 1'b1) begin miscompares++; $display("FAIL alu_wb_reg_wr got %b exp 1", wb_reg_wr); end
    step();
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL alu_bubble_after got %b exp 0", wb_valid); end
  endtask

  task automatic test_load_wait();
    ex_valid = 1; ex_mem_to_reg = 1; ex_reg_wr = 1; ex_rd = 3; ex_alu_result = 64'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL ldur_stall[%0d] got %b exp 1", i, stall); end
      vectors++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_addr !== 64'h40 || dmem.dmem_we !== 1'b0)
        begin miscompares++; $display("FAIL ldur_bus[%0d] got req=%b addr=%h we=%b exp 1/40/0", i, dmem.dmem_req, dmem.dmem_addr, dmem.dmem_we); end
      step();
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL ldur_bubble[%0d] got %b exp 0", i, wb_valid); end
    end
    dmem.dmem_ack = 1; dmem.dmem_rdata = 64'hDEADBEEF_CAFEF00D;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL ldur_ack_stall got %b exp 0", stall); end
    step();
    idle_inputs();
    vectors++; if (wb_valid !== 1'b1 || wb_reg_wr !== 1'b1 || wb_rd !== 5'd3)
      begin miscompares++; $display("FAIL ldur_wb_ctl got v=%b we=%b rd=%0d exp 1/1/3", wb_valid, wb_reg_wr, wb_rd); end
    vectors++; if (wb_result !== 64'hDEADBEEF_CAFEF00D) begin miscompares++; $display("FAIL ldur_wb_result got %h exp deadbeefcafef00d", wb_result); end
    #1;
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL ldur_back_idle_req got %b exp 0", dmem.dmem_req); end
  endtask

  task automatic test_sturb();
    ex_valid = 1; ex_mem_wr = 1; ex_byte = 1; ex_alu_result = 64'h43; ex_db = 64'h00000000_000000AB; ex_rd = 7;
    dmem.dmem_ack = 1;
    #1;
    vectors++; if (dmem.dmem_be !== 8'h08) begin miscompares++; $display("FAIL sturb_be got %h exp 08", dmem.dmem_be); end
    vectors++; if (dmem.dmem_wdata !== 64'hABABABAB_ABABABAB) begin miscompares++; $display("FAIL sturb_wdata got %h exp abababababababab", dmem.dmem_wdata); end
    vectors++; if (dmem.dmem_we !== 1'b1 || dmem.dmem_addr !== 64'h40) begin miscompares++; $display("FAIL sturb_we_addr got %b/%h exp 1/40", dmem.dmem_we, dmem.dmem_addr); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL sturb_stall got %b exp 0", stall); end
    step();
    idle_inputs();
    vectors++; if (wb_valid !== 1'b1 || wb_reg_wr !== 1'b0) begin miscompares++; $display("FAIL sturb_wb got v=%b we=%b exp 1/0", wb_valid, wb_reg_wr); end
    vectors++; if (wb_result !== 64'h43) begin miscompares++; $display("FAIL sturb_wb_result got %h exp 43", wb_result); end
  endtask

  task automatic test_ldurb();
    ex_valid = 1; ex_mem_to_reg = 1; ex_reg_wr = 1; ex_byte = 1; ex_rd = 9; ex_alu_result = 64'h45;
    dmem.dmem_ack = 1; dmem.dmem_rdata = 64'h00112233_44556677;
    #1;
    vectors++; if (stall !== 1'b0 || dmem.dmem_req !== 1'b1) begin miscompares++; $display("FAIL ldurb_req got stall=%b req=%b exp 0/1", stall, dmem.dmem_req); end
    step();
    idle_inputs();
    vectors++; if (wb_result !== 64'h22) begin miscompares++; $display("FAIL ldurb_result got %h exp 22", wb_result); end
    vectors++; if (wb_reg_wr !== 1'b1 || wb_rd !== 5'd9) begin miscompares++; $display("FAIL ldurb_ctl got we=%b rd=%0d exp 1/9", wb_reg_wr, wb_rd); end
  endtask

  task automatic test_both_flags_store();
    ex_valid = 1; ex_mem_wr = 1; ex_mem_to_reg = 1; ex_reg_wr = 1; ex_rd = 4;
    ex_alu_result = 64'h80; ex_db = 64'h11223344_55667788; dmem.dmem_ack = 1;
    #1;
    vectors++; if (dmem.dmem_be !== 8'hFF || dmem.dmem_wdata !== 64'h11223344_55667788 || dmem.dmem_we !== 1'b1)
      begin miscompares++; $display("FAIL stur_bus got be=%h wd=%h we=%b exp ff/1122334455667788/1", dmem.dmem_be, dmem.dmem_wdata, dmem.dmem_we); end
    step();
    idle_inputs();
    vectors++; if (wb_reg_wr !== 1'b0 || wb_result !== 64'h80) begin miscompares++; $display("FAIL stur_wb got we=%b res=%h exp 0/80", wb_reg_wr, wb_result); end
  endtask

  task automatic test_misaligned();
    ex_valid = 1; ex_mem_to_reg = 1; ex_reg_wr = 1; ex_rd = 2; ex_alu_result = 64'h44;
    #1;
    vectors++; if (dmem.dmem_req !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL misal_req got req=%b stall=%b exp 0/0", dmem.dmem_req, stall); end
    step();
    idle_inputs();
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL misal_fault got %b exp 1", fault); end
    vectors++; if (wb_valid !== 1'b1 || wb_reg_wr !== 1'b0) begin miscompares++; $display("FAIL misal_wb got v=%b we=%b exp 1/0", wb_valid, wb_reg_wr); end
    step();
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL misal_fault_pulse got %b exp 0", fault); end
  endtask

  task automatic test_timeout();
    int stall_cycles = 0;
    ex_valid = 1; ex_mem_to_reg = 1; ex_reg_wr = 1; ex_rd = 6; ex_alu_result = 64'h48;
    #1;
    for (int i = 0; i < 40 && stall; i++) begin
      step();
      stall_cycles++;
    end
    vectors++; if (stall_cycles !== 15) begin miscompares++; $display("FAIL timeout_stall_cycles got %0d exp 15", stall_cycles); end
    vectors++; if (dmem.dmem_req !== 1'b1 || stall !== 1'b0) begin miscompares++; $display("FAIL timeout_abort_cycle got req=%b stall=%b exp 1/0", dmem.dmem_req, stall); end
    vectors++; if (fault !== 1'b0 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL timeout_pre_fault got f=%b v=%b exp 0/0", fault, wb_valid); end
    step();
    idle_inputs();
    vectors++; if (fault !== 1'b1 || wb_valid !== 1'b1 || wb_reg_wr !== 1'b0)
      begin miscompares++; $display("FAIL timeout_fault got f=%b v=%b we=%b exp 1/1/0", fault, wb_valid, wb_reg_wr); end
    step();
    vectors++; if (fault !== 1'b0 || dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL timeout_idle got f=%b req=%b exp 0/0", fault, dmem.dmem_req); end
  endtask

  task automatic test_reset_mid_wait();
    ex_valid = 1; ex_mem_to_reg = 1; ex_reg_wr = 1; ex_rd = 8; ex_alu_result = 64'h50;
    step(); step();
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rstwait_in_wait got stall=%b exp 1", stall); end
    rst = 1;
    step();
    rst = 0;
    idle_inputs();
    dmem.dmem_ack = 1; dmem.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    vectors++; if (wb_valid !== 1'b0 || wb_result !== 64'h0 || wb_rd !== 5'd0 || fault !== 1'b0)
      begin miscompares++; $display("FAIL rstwait_regs got v=%b res=%h rd=%0d f=%b exp 0/0/0/0", wb_valid, wb_result, wb_rd, fault); end
    vectors++; if (dmem.dmem_req !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL rstwait_req got req=%b stall=%b exp 0/0", dmem.dmem_req, stall); end
    step();
    vectors++; if (wb_valid !== 1'b0 || wb_result !== 64'h0) begin miscompares++; $display("FAIL rstwait_ack_ignored got v=%b res=%h exp 0/0", wb_valid, wb_result); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    ex_valid = 1; ex_alu_result = 64'hAAAA; ex_rd = 10; ex_reg_wr = 1;
    step();
    vectors++; if (wb_result !== 64'hAAAA || wb_rd !== 5'd10) begin miscompares++; $display("FAIL b2b_first got %h/%0d exp aaaa/10", wb_result, wb_rd); end
    ex_alu_result = 64'h5555; ex_rd = 11; ex_reg_wr = 0;
    step();
    idle_inputs();
    vectors++; if (wb_result !== 64'h5555 || wb_rd !== 5'd11 || wb_reg_wr !== 1'b0 || wb_valid !== 1'b1)
      begin miscompares++; $display("FAIL b2b_second got %h/%0d/%b/%b exp 5555/11/0/1", wb_result, wb_rd, wb_reg_wr, wb_valid); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_sturb();
    test_ldurb();
    test_both_flags_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
